// File: rtl/bronco_params_pkg.sv
// bronco_params: shared sizes, op-code and FSM encodings for the matrix-core
// fetch path, plus the beat-index to memory-address mapping.
package bronco_params;

  localparam int MAT_DIM    = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  localparam int W_DEPTH = MAT_DIM * MAT_DIM;
  localparam int X_DEPTH = MAT_DIM;
  localparam int TOTAL   = W_DEPTH + X_DEPTH;

  // Beat counters must be able to hold TOTAL itself ("all requests issued").
  localparam int BEAT_W = $clog2(TOTAL + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [BEAT_W-1:0]     beat_t;

  localparam beat_t BEAT_ONE  = beat_t'(1);
  localparam beat_t W_DEPTH_B = beat_t'(W_DEPTH);
  localparam beat_t TOTAL_B   = beat_t'(TOTAL);
  localparam beat_t LAST_B    = beat_t'(TOTAL - 1);

  // Host command encoding on op_code.
  typedef enum logic [1:0] {
    OP_SET_W = 2'b00,
    OP_SET_X = 2'b01,
    OP_RUN   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Request FSM: IDLE, REQ (request on the bus), WAIT (one read in flight),
  // OUT (response buffered, waiting for room or for the final drain).
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_OUT  = 2'b11
  } state_e;

  // W beats come first, then X beats; the add wraps modulo 2^ADDR_WIDTH.
  function automatic addr_t beat_addr(input addr_t w_base, input addr_t x_base,
                                      input beat_t idx);
    if (idx < W_DEPTH_B)
      return w_base + addr_t'(idx);
    else
      return x_base + addr_t'(idx - W_DEPTH_B);
  endfunction

endpackage

// File: rtl/fetch_engine_out_buf.sv
// fetch_out_buf: small valid/ready holding buffer on the stream side.
// DEPTH=1 is a single output register; DEPTH=2 is a shift FIFO whose head
// entry drives out_data directly, so the output stays registered.
// has_room tells the requester a slot will be free after this cycle's pop.
module fetch_out_buf
  import bronco_params::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_vld,
  input  data_t in_data,
  output logic  has_room,
  output logic  out_vld,
  input  logic  out_rdy,
  output data_t out_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  data_t            mem   [DEPTH];
  data_t            mem_n [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             push;
  logic             pop;

  assign out_vld  = (count != '0);
  assign out_data = mem[0];
  assign pop      = out_vld && out_rdy;
  assign has_room = (count != DEPTH_C) || pop;
  assign push     = in_vld && has_room;

  // Next-state: pop shifts toward the head, push lands in the first free slot.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    mem_n   = mem;
    count_n = count;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      count_n = count - CNT_ONE;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_n == CNT_W'(i)) mem_n[i] = in_data;
      end
      count_n = count_n + CNT_ONE;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      // NOTE: the data slots are reset too, because src_data must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: state uses <= so every register updates from pre-edge values.
      count <= count_n;
      mem   <= mem_n;
    end
  end

endmodule

// File: rtl/fetch_engine.sv
// fetch_engine: host-programmed fetcher for the matrix core. The host loads
// W/X base addresses and issues RUN; the block reads W_DEPTH W words then
// X_DEPTH X words through a single-outstanding memory port and streams them
// in order over valid/ready.
// Build option: define FETCH_PREFETCH_EN to give the stream side a 2-entry
// buffer so the next read overlaps a stalled sink; otherwise each beat is
// strictly request -> response -> drain through one holding register.
module fetch_engine
  import bronco_params::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op_code,
  input  logic [ADDR_WIDTH-1:0] cfg_data,
  output logic                  m_req_vld,
  input  logic                  m_req_rdy,
  output logic [ADDR_WIDTH-1:0] m_req_addr,
  input  logic                  m_rsp_vld,
  input  logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  busy
);

`ifdef FETCH_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  state_e state;
  op_e    op;
  addr_t  w_base;
  addr_t  x_base;
  beat_t  req_idx;   // requests accepted by memory this run
  beat_t  out_cnt;   // beats handed to the core this run
  logic   rsp_take;
  logic   buf_pop;
  logic   buf_room;

  assign op = op_e'(op_code);

  // Responses count only while a read is in flight; strays are dropped.
  assign rsp_take = (state == S_WAIT) && m_rsp_vld;
  assign buf_pop  = src_vld && src_rdy;

  fetch_out_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rsp_take),
    .in_data  (m_rsp_data),
    .has_room (buf_room),
    .out_vld  (src_vld),
    .out_rdy  (src_rdy),
    .out_data (src_data)
  );

  // Command decode, request FSM, base registers and beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      m_req_vld  <= 1'b0;
      m_req_addr <= '0;
      w_base     <= '0;
      x_base     <= '0;
      req_idx    <= '0;
      out_cnt    <= '0;
    end else begin
      if (buf_pop) out_cnt <= out_cnt + BEAT_ONE;

      case (state)
        // Commands are only honoured here, i.e. while not busy.
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_SET_W: w_base <= cfg_data;
              OP_SET_X: x_base <= cfg_data;
              OP_RUN: begin
                busy       <= 1'b1;
                req_idx    <= '0;
                out_cnt    <= '0;
                m_req_vld  <= 1'b1;
                m_req_addr <= beat_addr(w_base, x_base, '0);
                state      <= S_REQ;
              end
              default: ;
            endcase
          end
        end

        // Hold the address until memory takes it.
        S_REQ: begin
          if (m_req_rdy) begin
            m_req_vld <= 1'b0;
            req_idx   <= req_idx + BEAT_ONE;
            state     <= S_WAIT;
          end
        end

        // The buffer captures the data on the same edge.
        S_WAIT: begin
          if (m_rsp_vld) state <= S_OUT;
        end

        // Issue the next read once a slot is guaranteed for its data, or
        // finish when the last beat leaves.
        S_OUT: begin
          if (req_idx == TOTAL_B) begin
            if (buf_pop && (out_cnt == LAST_B)) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (buf_room) begin
            m_req_vld  <= 1'b1;
            m_req_addr <= beat_addr(w_base, x_base, req_idx);
            state      <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_engine.sv
// tb_fetch_engine: scenario table plus hand sequences for fetch_engine.
// A reference model lists the expected address/data stream from the base
// registers and a memory image; a randomized memory/sink model checks every
// request and beat against it.
module tb_fetch_engine;
  import bronco_params::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op_code;
  logic [7:0] cfg_data;
  logic       m_req_vld;
  logic       m_req_rdy;
  logic [7:0] m_req_addr;
  logic       m_rsp_vld;
  logic [7:0] m_rsp_data;
  logic       src_vld;
  logic       src_rdy;
  logic [7:0] src_data;
  logic       busy;

  always #5 clk = ~clk;

  fetch_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_code    (op_code),
    .cfg_data   (cfg_data),
    .m_req_vld  (m_req_vld),
    .m_req_rdy  (m_req_rdy),
    .m_req_addr (m_req_addr),
    .m_rsp_vld  (m_rsp_vld),
    .m_rsp_data (m_rsp_data),
    .src_vld    (src_vld),
    .src_rdy    (src_rdy),
    .src_data   (src_data),
    .busy       (busy)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_addr [$];
  logic [7:0] exp_data [$];

  typedef struct {
    bit         do_set;
    logic [7:0] wb;
    logic [7:0] xb;
    int         req_pct;
    int         src_pct;
    int         max_lat;
    bit         rand_mem;
    int         inject_beat;
    int         abort_beat;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } scen_t;

  scen_t scen [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected stream: W words from wb upward, then X words from xb upward,
  // addresses wrapping at 256, data read from the memory image.
  function automatic void build_model(input logic [7:0] wb, input logic [7:0] xb);
    logic [7:0] a;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < TOTAL; i++) begin
      if (i < W_DEPTH) a = 8'((int'(wb) + i) % 256);
      else             a = 8'((int'(xb) + i - W_DEPTH) % 256);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
  endfunction

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic cmd(input logic [1:0] op, input logic [7:0] d);
    start    = 1'b1;
    op_code  = op;
    cfg_data = d;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Runs one RUN to completion (or abort) with a random memory and sink.
  task automatic run_stream(input scen_t sc, input int sid);
    int         reqs = 0;
    int         beats = 0;
    int         timer = 0;
    int         inj = 0;
    bit         done = 0;
    logic       outstanding = 1'b0;
    logic       pulse_on = 1'b0;
    logic       req_stall = 1'b0;
    logic       src_stall = 1'b0;
    logic [7:0] rsp_addr = '0;
    logic [7:0] last_addr = '0;
    logic [7:0] last_data = '0;

    check($sformatf("s%0d_run_latency", sid), {busy, m_req_vld}, 2'b11);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (beats == TOTAL) begin
        check($sformatf("s%0d_busy_after_last", sid), busy, 1'b0);
        check($sformatf("s%0d_src_vld_after_last", sid), src_vld, 1'b0);
        done = 1;
      end else if (sc.abort_beat >= 0 && beats == sc.abort_beat) begin
        rst       = 1'b1;
        start     = 1'b0;
        m_rsp_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("s%0d_abort_req_vld", sid), m_req_vld, 1'b0);
        check($sformatf("s%0d_abort_req_addr", sid), m_req_addr, 8'h00);
        check($sformatf("s%0d_abort_src_vld", sid), src_vld, 1'b0);
        check($sformatf("s%0d_abort_src_data", sid), src_data, 8'h00);
        check($sformatf("s%0d_abort_busy", sid), busy, 1'b0);
        m_rsp_vld  = 1'b1;
        m_rsp_data = 8'hAA;
        @(negedge clk);
        m_rsp_vld = 1'b0;
        @(negedge clk);
        check($sformatf("s%0d_stray_src_vld", sid), src_vld, 1'b0);
        check($sformatf("s%0d_stray_busy", sid), busy, 1'b0);
        done = 1;
      end else begin
        check($sformatf("s%0d_busy_during_run", sid), busy, 1'b1);

        if (pulse_on) begin
          m_rsp_vld   = 1'b0;
          pulse_on    = 1'b0;
          outstanding = 1'b0;
        end
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            m_rsp_vld  = 1'b1;
            m_rsp_data = mem[rsp_addr];
            pulse_on   = 1'b1;
          end
        end

        if (req_stall) begin
          check($sformatf("s%0d_req_hold_vld", sid), m_req_vld, 1'b1);
          check($sformatf("s%0d_req_hold_addr", sid), m_req_addr, last_addr);
        end
        if (src_stall) begin
          check($sformatf("s%0d_src_hold_vld", sid), src_vld, 1'b1);
          check($sformatf("s%0d_src_hold_data", sid), src_data, last_data);
        end

        m_req_rdy = ($urandom_range(99) < sc.req_pct);
        src_rdy   = ($urandom_range(99) < sc.src_pct);

        if (m_req_vld && m_req_rdy) begin
          check($sformatf("s%0d_single_outstanding", sid), outstanding, 1'b0);
          check($sformatf("s%0d_req_in_range", sid), (reqs < TOTAL), 1'b1);
          if (reqs < TOTAL)
            check($sformatf("s%0d_addr%0d", sid, reqs), m_req_addr, exp_addr[reqs]);
          if (reqs == 0)
            check($sformatf("s%0d_first_addr", sid), m_req_addr, sc.exp_first);
          if (reqs == TOTAL - 1)
            check($sformatf("s%0d_last_addr", sid), m_req_addr, sc.exp_last);
          outstanding = 1'b1;
          timer       = int'($urandom_range(sc.max_lat, 1));
          rsp_addr    = m_req_addr;
          reqs++;
        end
        req_stall = m_req_vld && !m_req_rdy;
        last_addr = m_req_addr;

        if (src_vld && src_rdy) begin
          check($sformatf("s%0d_data%0d", sid, beats), src_data, exp_data[beats]);
          beats++;
        end
        src_stall = src_vld && !src_rdy;
        last_data = src_data;

        if (sc.inject_beat >= 0 && beats >= sc.inject_beat) begin
          case (inj)
            0: begin start = 1'b1; op_code = OP_SET_W; cfg_data = 8'h40; inj = 1; end
            1: begin op_code = OP_RUN; cfg_data = 8'h00; inj = 2; end
            2: begin start = 1'b0; inj = 3; end
            default: ;
          endcase
        end

        @(negedge clk);
      end
    end
    if (!done) check($sformatf("s%0d_timeout_beats", sid), beats, TOTAL);
    start     = 1'b0;
    m_req_rdy = 1'b0;
    src_rdy   = 1'b0;
    m_rsp_vld = 1'b0;
  endtask

  task automatic do_scenario(input scen_t sc, input int sid);
    for (int a = 0; a < 256; a++) mem[a] = sc.rand_mem ? 8'($urandom) : 8'(a);
    build_model(sc.wb, sc.xb);
    if (sc.do_set) begin
      cmd(OP_SET_W, sc.wb);
      cmd(OP_SET_X, sc.xb);
    end
    cmd(OP_RUN, 8'($urandom));
    run_stream(sc, sid);
  endtask

  initial begin
    scen_t tail;

    //          set  wb     xb     rq%  sk%  lat rnd inj abort first  last
    scen[0] = '{1'b1, 8'h10, 8'h80, 100, 100, 1, 1'b0, -1, -1, 8'h10, 8'h83};
    scen[1] = '{1'b1, 8'h10, 8'h80,  75,  75, 4, 1'b0, -1, -1, 8'h10, 8'h83};
    scen[2] = '{1'b1, 8'hF8, 8'hFE, 100, 100, 1, 1'b0, -1, -1, 8'hF8, 8'h01};
    scen[3] = '{1'b1, 8'h20, 8'hC0,  60,  50, 3, 1'b1,  5, -1, 8'h20, 8'hC3};
    scen[4] = '{1'b0, 8'h20, 8'hC0,  80,  70, 2, 1'b1, -1, -1, 8'h20, 8'hC3};
    scen[5] = '{1'b1, 8'h33, 8'h77,  75,  75, 4, 1'b1, -1,  7, 8'h33, 8'h7A};

    rst        = 1'b1;
    start      = 1'b0;
    op_code    = 2'b00;
    cfg_data   = 8'h00;
    m_req_rdy  = 1'b0;
    m_rsp_vld  = 1'b0;
    m_rsp_data = 8'h00;
    src_rdy    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_m_req_vld", m_req_vld, 1'b0);
    check("reset_m_req_addr", m_req_addr, 8'h00);
    check("reset_src_vld", src_vld, 1'b0);
    check("reset_src_data", src_data, 8'h00);
    check("reset_busy", busy, 1'b0);

    for (int s = 0; s < 6; s++) do_scenario(scen[s], s);

    // Reserved op-code must change nothing: still idle, bases stay at reset 0.
    cmd(OP_RSVD, 8'h55);
    @(negedge clk);
    check("rsvd_busy", busy, 1'b0);
    check("rsvd_m_req_vld", m_req_vld, 1'b0);
    check("rsvd_src_vld", src_vld, 1'b0);

    tail = '{1'b0, 8'h00, 8'h00, 90, 85, 2, 1'b0, -1, -1, 8'h00, 8'h03};
    do_scenario(tail, 6);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
